// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state type, default element width and sizing helpers
// for the matmul request scheduler (matmul_sched) and its arbiter.
package matmul_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } sched_state_t;

   localparam int unsigned DEF_DATA_W = 32;

   // Requester ID width: clog2(n), never less than one bit.
   function automatic int unsigned id_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Bits needed to hold any value in 0..max_v.
   function automatic int unsigned cnt_w(input int unsigned max_v);
      return (max_v < 2) ? 1 : $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/matmul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter. Grants the first asserted
// request found when searching upward from ptr, wrapping at N.
module rr_arbiter
   import matmul_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]       req,
   input  logic [id_w(N)-1:0] ptr,
   output logic [N-1:0]       gnt
);

   // priority search starting at ptr; at most one grant bit set
   always_comb begin
      logic found;
      found = 1'b0;
      gnt   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            if (!found && req[j] && (j == ((32'(ptr) + i) % N))) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/matmul_sched.sv
// matmul_sched: shares one pipelined matmul engine between NUM_REQ requesters.
// Round-robin grants in RUN, issue register toward the engine, a LATENCY-deep
// valid+ID pipeline that tags each engine result with its requester, and a
// registered one-hot response. Optional performance counters are built only
// when MATMUL_SCHED_PERF_EN is defined; otherwise the perf ports read zero.
module matmul_sched
   import matmul_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned IN_DIM  = 1,
   parameter int unsigned OUT_DIM = 1,
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned LATENCY = 2
) (
   input  logic                                     clk,
   input  logic                                     reset_n,
   input  logic                                     en,
   input  logic [NUM_REQ-1:0]                       req_valid,
   output logic [NUM_REQ-1:0]                       req_ready,
   input  logic [NUM_REQ-1:0][IN_DIM-1:0][DATA_W-1:0] req_vec,
   output logic                                     eng_valid,
   output logic [IN_DIM-1:0][DATA_W-1:0]            eng_vec_in,
   input  logic [OUT_DIM-1:0][DATA_W-1:0]           eng_vec_out,
   output logic [NUM_REQ-1:0]                       rsp_valid,
   output logic [OUT_DIM-1:0][DATA_W-1:0]           rsp_vec,
   output logic                                     busy,
   output logic [31:0]                              perf_issued,
   output logic [31:0]                              perf_busy
);

   localparam int unsigned ID_W = id_w(NUM_REQ);
   localparam int unsigned IF_W = cnt_w(LATENCY + 2);

   sched_state_t                      r_state;
   logic [ID_W-1:0]                   r_rr_ptr;
   logic [IF_W-1:0]                   r_inflight;
   logic                              r_eng_valid;
   logic [ID_W-1:0]                   r_eng_id;
   logic [IN_DIM-1:0][DATA_W-1:0]     r_eng_vec;
   logic [LATENCY-1:0]                r_pipe_vld;
   logic [LATENCY-1:0][ID_W-1:0]      r_pipe_id;
   logic [NUM_REQ-1:0]                r_rsp_valid;
   logic [OUT_DIM-1:0][DATA_W-1:0]    r_rsp_vec;

   logic [NUM_REQ-1:0]                w_arb_gnt;
   logic [NUM_REQ-1:0]                w_gnt;
   logic                              w_grant;
   logic [ID_W-1:0]                   w_gnt_id;
   logic [IN_DIM-1:0][DATA_W-1:0]     w_gnt_vec;
   logic                              w_rsp_fire;
   logic [ID_W-1:0]                   w_rsp_id;
   logic [NUM_REQ-1:0]                w_rsp_onehot;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .gnt (w_arb_gnt)
   );

   // grants are only offered while running
   assign w_gnt     = (r_state == S_RUN) ? w_arb_gnt : '0;
   assign w_grant   = |w_gnt;
   assign req_ready = w_gnt;

   assign w_rsp_fire = r_pipe_vld[LATENCY-1];
   assign w_rsp_id   = r_pipe_id[LATENCY-1];

   assign busy       = (r_state != S_IDLE);
   assign eng_valid  = r_eng_valid;
   assign eng_vec_in = r_eng_vec;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_vec    = r_rsp_vec;

   // encode the one-hot winner and mux out its vector (zero when no grant)
   always_comb begin
      w_gnt_id  = '0;
      w_gnt_vec = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_gnt_id  = ID_W'(i);
            w_gnt_vec = req_vec[i];
         end
      end
   end

   // decode the ID leaving the pipeline into the one-hot response strobe
   always_comb begin
      w_rsp_onehot = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_rsp_id == ID_W'(i)) w_rsp_onehot[i] = w_rsp_fire;
      end
   end

   // scheduler FSM: IDLE -> RUN on en, leave RUN when en drops, DRAIN until empty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (en) r_state <= S_RUN;
            S_RUN:   if (!en) r_state <= (r_inflight != '0) ? S_DRAIN : S_IDLE;
            S_DRAIN: if (r_inflight == '0) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // round-robin pointer moves past the winner, holds otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= '0;
      end else if (w_grant) begin
         r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
   end

   // outstanding count: a response is counted when it is captured for output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight <= '0;
      end else begin
         case ({w_grant, w_rsp_fire})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // issue register toward the engine plus the ID pipeline tracking it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_eng_valid <= 1'b0;
         r_eng_id    <= '0;
         r_eng_vec   <= '0;
         r_pipe_vld  <= '0;
         r_pipe_id   <= '0;
      end else begin
         r_eng_valid   <= w_grant;
         r_eng_id      <= w_gnt_id;
         r_eng_vec     <= w_gnt_vec;
         r_pipe_vld[0] <= r_eng_valid;
         r_pipe_id[0]  <= r_eng_id;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_id[i]  <= r_pipe_id[i-1];
         end
      end
   end

   // register the engine result against its ID; zero data when nothing fires
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rsp_valid <= '0;
         r_rsp_vec   <= '0;
      end else begin
         r_rsp_valid <= w_rsp_onehot;
         r_rsp_vec   <= w_rsp_fire ? eng_vec_out : '0;
      end
   end

`ifdef MATMUL_SCHED_PERF_EN
   logic [31:0] r_perf_issued;
   logic [31:0] r_perf_busy;

   // free-running wrap-around counters of grants and busy cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_issued <= '0;
         r_perf_busy   <= '0;
      end else begin
         if (w_grant) r_perf_issued <= r_perf_issued + 32'd1;
         if (busy)    r_perf_busy   <= r_perf_busy + 32'd1;
      end
   end

   assign perf_issued = r_perf_issued;
   assign perf_busy   = r_perf_busy;
`else
   assign perf_issued = '0;
   assign perf_busy   = '0;
`endif

endmodule
